// File: rtl/rd_contrl.sv
// rd_contrl: read-side pointer and flag controller for an asynchronous FIFO.
// Runs entirely in the r_clk domain. Keeps the binary read pointer (memory
// address), exports a Gray read pointer for the write-domain synchronizer and
// derives a registered empty flag from the already-synchronized write pointer.
// Optional feature macro: RD_LEVEL_EN builds the occupancy count (rlevel) and
// the almost-empty flag (raempty); without it rlevel=0 and raempty=1.
module rd_contrl #(
    parameter int ADDR_WIDTH    = 4,
    parameter int AEMPTY_THRESH = 2
) (
    input  logic                  r_clk,
    input  logic                  r_rst,
    input  logic                  rinc,
    input  logic [ADDR_WIDTH:0]   w_ptr,
    output logic                  rempty,
    output logic                  raempty,
    output logic [ADDR_WIDTH:0]   rlevel,
    output logic [ADDR_WIDTH:0]   r_ptr,
    output logic [ADDR_WIDTH-1:0] raddr
);

    localparam int PW = ADDR_WIDTH + 1;

    logic [PW-1:0] rbin_q, rbin_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic          rempty_q, rempty_d;
    logic          rd_en;

    // Next pointer: advance only when a read is requested and data exists,
    // so a read against an empty FIFO is simply dropped.
    always_comb begin
        rd_en    = rinc & ~rempty_q;
        rbin_d   = rbin_q + {{ADDR_WIDTH{1'b0}}, rd_en};
        rptr_d   = rbin_d ^ (rbin_d >> 1);
        // Compare the post-read Gray pointer so the last read sets empty on
        // the same edge, with no bubble.
        rempty_d = (rptr_d == w_ptr);
    end

    // Pointer and empty registers; reset wins over any read in flight.
    always_ff @(posedge r_clk) begin
        if (r_rst) begin
            rbin_q   <= '0;
            rptr_q   <= '0;
            rempty_q <= 1'b1;
        end else begin
            rbin_q   <= rbin_d;
            rptr_q   <= rptr_d;
            rempty_q <= rempty_d;
        end
    end

    assign raddr  = rbin_q[ADDR_WIDTH-1:0];
    assign r_ptr  = rptr_q;
    assign rempty = rempty_q;

`ifdef RD_LEVEL_EN
    localparam logic [PW-1:0] AE_TH = PW'(AEMPTY_THRESH);

    logic [PW-1:0] wbin;
    logic [PW-1:0] rlevel_q, rlevel_d;
    logic          raempty_q, raempty_d;

    // Gray-to-binary of the write pointer: bit i is the XOR of all Gray bits
    // at or above i. Level is the modular distance to the next read pointer.
    always_comb begin
        wbin = '0;
        for (int i = 0; i < PW; i++) begin
            wbin[i] = ^(w_ptr >> i);
        end
        rlevel_d  = wbin - rbin_d;
        raempty_d = (rlevel_d <= AE_TH);
    end

    // Occupancy and almost-empty registers.
    always_ff @(posedge r_clk) begin
        if (r_rst) begin
            rlevel_q  <= '0;
            raempty_q <= 1'b1;
        end else begin
            rlevel_q  <= rlevel_d;
            raempty_q <= raempty_d;
        end
    end

    assign rlevel  = rlevel_q;
    assign raempty = raempty_q;
`else
    assign rlevel  = '0;
    assign raempty = 1'b1;
`endif

endmodule
